// File: rtl/tmds_encoder_multi.sv
// N-channel TMDS/HDMI symbol encoder: control, 8b/10b video with DC balance,
// guard bands and TERC4 data islands. Two-stage pipeline, fixed 2-cycle latency.

module tmds_enc_ch #(
    parameter int CH_IDX = 0,
    parameter int DISP_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        i_mode,
    input  logic [7:0]        i_data,
    input  logic [3:0]        i_terc4,
    input  logic [1:0]        i_ctrl,
    output logic [9:0]        o_tmds,
    output logic [DISP_W-1:0] o_disp
);
    localparam logic [2:0] MODE_CTRL  = 3'd0;
    localparam logic [2:0] MODE_VIDEO = 3'd1;
    localparam logic [2:0] MODE_VGB   = 3'd2;
    localparam logic [2:0] MODE_DATA  = 3'd3;
    localparam logic [2:0] MODE_DGB   = 3'd4;
    localparam logic IS_SYNC = (CH_IDX == 0);
    localparam logic IS_EVEN = (CH_IDX % 2 == 0);
    localparam logic [DISP_W-1:0] TWO   = DISP_W'(2);
    localparam logic [DISP_W-1:0] EIGHT = DISP_W'(8);

    function automatic logic [9:0] f_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   f_ctrl = 10'b1101010100;
            2'b01:   f_ctrl = 10'b0010101011;
            2'b10:   f_ctrl = 10'b0101010100;
            default: f_ctrl = 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] f_terc4(input logic [3:0] n);
        case (n)
            4'h0:    f_terc4 = 10'b1010011100;
            4'h1:    f_terc4 = 10'b1001100011;
            4'h2:    f_terc4 = 10'b1011100100;
            4'h3:    f_terc4 = 10'b1011100010;
            4'h4:    f_terc4 = 10'b0101110001;
            4'h5:    f_terc4 = 10'b0100011110;
            4'h6:    f_terc4 = 10'b0110001110;
            4'h7:    f_terc4 = 10'b0100111100;
            4'h8:    f_terc4 = 10'b1011001100;
            4'h9:    f_terc4 = 10'b0100111001;
            4'hA:    f_terc4 = 10'b0110011100;
            4'hB:    f_terc4 = 10'b1011000111;
            4'hC:    f_terc4 = 10'b1010001110;
            4'hD:    f_terc4 = 10'b1001110001;
            4'hE:    f_terc4 = 10'b0101100011;
            default: f_terc4 = 10'b1011000011;
        endcase
    endfunction

    // ---------------- stage 1: q_m, its ones count, symbol selects
    logic [2:0] w_mode;
    logic [3:0] w_sel;
    logic [3:0] w_ones;
    logic [3:0] w_qn1;
    logic       w_xnor;
    logic [8:0] w_qm;

    always_comb begin
        w_mode = (i_mode > MODE_DGB) ? MODE_CTRL : i_mode;
        w_ones = '0;
        for (int i = 0; i < 8; i++) w_ones = w_ones + 4'(i_data[i]);
        w_xnor = (w_ones > 4'd4) || (w_ones == 4'd4 && !i_data[0]);
        w_qm    = '0;
        w_qm[0] = i_data[0];
        for (int i = 1; i < 8; i++)
            w_qm[i] = w_xnor ? ~(w_qm[i-1] ^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
        w_qm[8] = ~w_xnor;
        w_qn1 = '0;
        for (int i = 0; i < 8; i++) w_qn1 = w_qn1 + 4'(w_qm[i]);
        // Only channel 0 carries sync; other channels always select code 00
        case (w_mode)
            MODE_DATA: w_sel = i_terc4;
            MODE_DGB:  w_sel = IS_SYNC ? {2'b11, i_ctrl} : 4'd0;
            MODE_CTRL: w_sel = IS_SYNC ? {2'b00, i_ctrl} : 4'd0;
            default:   w_sel = 4'd0;
        endcase
    end

    logic [2:0] r_mode;
    logic [8:0] r_qm;
    logic [3:0] r_n1;
    logic [3:0] r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_CTRL;
            r_qm   <= '0;
            r_n1   <= '0;
            r_sel  <= '0;
        end else begin
            r_mode <= w_mode;
            r_qm   <= w_qm;
            r_n1   <= w_qn1;
            r_sel  <= w_sel;
        end
    end

    // ---------------- stage 2: DC balance and final symbol
    logic [DISP_W-1:0] r_cnt;
    logic [9:0]        r_tmds;
    logic [DISP_W-1:0] w_diff;
    logic [DISP_W-1:0] w_q8x2;
    logic [DISP_W-1:0] w_nq8x2;
    logic [DISP_W-1:0] w_vcnt;
    logic [DISP_W-1:0] w_cnt_nxt;
    logic [9:0]        w_vsym;
    logic [9:0]        w_sym;
    logic              w_q8, w_zero, w_pos, w_neg, w_n1gt, w_bal;

    always_comb begin
        w_q8    = r_qm[8];
        w_diff  = (DISP_W'(r_n1) << 1) - EIGHT;   // n1 - n0
        w_q8x2  = w_q8 ? TWO : '0;
        w_nq8x2 = w_q8 ? '0 : TWO;
        w_zero  = (r_cnt == '0);
        w_neg   = r_cnt[DISP_W-1];
        w_pos   = !w_neg && !w_zero;
        w_n1gt  = (r_n1 > 4'd4);
        w_bal   = (r_n1 == 4'd4);
        if (w_zero || w_bal) begin
            w_vsym = {~w_q8, w_q8, w_q8 ? r_qm[7:0] : ~r_qm[7:0]};
            w_vcnt = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if ((w_pos && w_n1gt) || (w_neg && !w_n1gt)) begin
            w_vsym = {1'b1, w_q8, ~r_qm[7:0]};
            w_vcnt = r_cnt + w_q8x2 - w_diff;
        end else begin
            w_vsym = {1'b0, w_q8, r_qm[7:0]};
            w_vcnt = r_cnt - w_nq8x2 + w_diff;
        end
        // Any non-video symbol restarts the disparity tally
        w_cnt_nxt = '0;
        case (r_mode)
            MODE_VIDEO: begin
                w_sym     = w_vsym;
                w_cnt_nxt = w_vcnt;
            end
            MODE_VGB:  w_sym = IS_EVEN ? 10'b1011001100 : 10'b0100110011;
            MODE_DATA: w_sym = f_terc4(r_sel);
            MODE_DGB:  w_sym = IS_SYNC ? f_terc4(r_sel) : 10'b0100110011;
            default:   w_sym = f_ctrl(r_sel[1:0]);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmds <= '0;
            r_cnt  <= '0;
        end else begin
            r_tmds <= w_sym;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_tmds = r_tmds;
    assign o_disp = r_cnt;
endmodule

module tmds_encoder_multi #(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [2:0]               mode_in,
    input  logic [NUM_CH*8-1:0]      data_in,
    input  logic [NUM_CH*4-1:0]      terc4_in,
    input  logic [1:0]               control_in,
    output logic [NUM_CH*10-1:0]     tmds_out,
    output logic [NUM_CH*DISP_W-1:0] disp_out
);
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tmds_enc_ch #(
            .CH_IDX (k),
            .DISP_W (DISP_W)
        ) u_ch (
            .clk     (clk_in),
            .rst_n   (rst_n_in),
            .i_mode  (mode_in),
            .i_data  (data_in[8*k +: 8]),
            .i_terc4 (terc4_in[4*k +: 4]),
            .i_ctrl  (control_in),
            .o_tmds  (tmds_out[10*k +: 10]),
            .o_disp  (disp_out[DISP_W*k +: DISP_W])
        );
    end
endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: directed symbol checks plus random streams
// compared against a behavioural encoder model, on 3-, 1- and 4-channel builds.

module tb_tmds_encoder_multi;
    localparam int DW = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  mode;
    logic [1:0]  ctrl;
    logic [31:0] data;
    logic [15:0] terc;

    logic [29:0] tmds3;  logic [14:0] disp3;
    logic [9:0]  tmds1;  logic [4:0]  disp1;
    logic [39:0] tmds4;  logic [19:0] disp4;

    always #5 clk = ~clk;

    tmds_encoder_multi #(.NUM_CH(3), .DISP_W(DW)) u_dut3 (
        .clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .data_in(data[23:0]),
        .terc4_in(terc[11:0]), .control_in(ctrl), .tmds_out(tmds3), .disp_out(disp3));
    tmds_encoder_multi #(.NUM_CH(1), .DISP_W(DW)) u_dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .data_in(data[7:0]),
        .terc4_in(terc[3:0]), .control_in(ctrl), .tmds_out(tmds1), .disp_out(disp1));
    tmds_encoder_multi #(.NUM_CH(4), .DISP_W(DW)) u_dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .mode_in(mode), .data_in(data),
        .terc4_in(terc), .control_in(ctrl), .tmds_out(tmds4), .disp_out(disp4));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    typedef struct {
        logic [39:0] sym;
        logic [19:0] disp;
        logic [2:0]  mode;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   cnt_m[4];

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] t[4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
        return t[c];
    endfunction

    function automatic logic [9:0] terc_code(input logic [3:0] n);
        logic [9:0] t[16] = '{
            10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
            10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
            10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000111,
            10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
        return t[n];
    endfunction

    // Textbook DVI encoding with integer disparity
    task automatic video_enc(input logic [7:0] d, inout int cnt, output logic [9:0] s);
        logic [8:0] qm;
        int ones, n1, n0;
        bit use_xnor;
        ones = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (cnt == 0 || n1 == n0) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt += qm[8] ? (n1 - n0) : (n0 - n1);
        end else if ((cnt > 0 && n1 > n0) || (cnt < 0 && n0 > n1)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            cnt += (qm[8] ? 2 : 0) + (n0 - n1);
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            cnt += (qm[8] ? 0 : -2) + (n1 - n0);
        end
    endtask

    function automatic logic [7:0] video_dec(input logic [9:0] s);
        logic [7:0] qv, d;
        qv = s[9] ? ~s[7:0] : s[7:0];
        d[0] = qv[0];
        for (int i = 1; i < 8; i++)
            d[i] = s[8] ? (qv[i] ^ qv[i-1]) : ~(qv[i] ^ qv[i-1]);
        return d;
    endfunction

    task automatic model_push(input logic [2:0] m, input logic [1:0] c,
                              input logic [31:0] d, input logic [15:0] t);
        exp_t e;
        logic [9:0] s;
        e.mode = m;
        e.data = d;
        for (int k = 0; k < 4; k++) begin
            case (m)
                3'd1: video_enc(d[8*k +: 8], cnt_m[k], s);
                3'd2: s = (k % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
                3'd3: s = terc_code(t[4*k +: 4]);
                3'd4: s = (k == 0) ? terc_code({2'b11, c}) : 10'b0100110011;
                default: s = (k == 0) ? ctrl_code(c) : ctrl_code(2'b00);
            endcase
            if (m != 3'd1) cnt_m[k] = 0;
            e.sym[10*k +: 10] = s;
            e.disp[DW*k +: DW] = DW'(cnt_m[k]);
        end
        q.push_back(e);
    endtask

    task automatic drive(input logic [2:0] m, input logic [1:0] c,
                         input logic [31:0] d, input logic [15:0] t);
        exp_t e;
        int v;
        mode = m; ctrl = c; data = d; terc = t;
        model_push(m, c, d, t);
        @(posedge clk);
        #1;
        if (q.size() >= 2) begin
            e = q.pop_front();
            chk("sym3",  64'(tmds3), 64'(e.sym[29:0]));
            chk("disp3", 64'(disp3), 64'(e.disp[14:0]));
            chk("sym1",  64'(tmds1), 64'(e.sym[9:0]));
            chk("disp1", 64'(disp1), 64'(e.disp[4:0]));
            chk("sym4",  64'(tmds4), 64'(e.sym));
            chk("disp4", 64'(disp4), 64'(e.disp));
            if (e.mode == 3'd1) begin
                for (int k = 0; k < 4; k++) begin
                    chk("decode", 64'(video_dec(tmds4[10*k +: 10])), 64'(e.data[8*k +: 8]));
                    v = int'($signed(disp4[DW*k +: DW]));
                    chk("disp_bound", 64'(v >= -10 && v <= 10), 64'd1);
                end
            end
        end
    endtask

    task automatic lit(input string tag, input int k, input logic [9:0] exp);
        chk(tag, 64'(tmds3[10*k +: 10]), 64'(exp));
    endtask

    task automatic lit_disp(input string tag, input logic [4:0] exp);
        chk(tag, 64'(disp3[4:0]), 64'(exp));
    endtask

    initial begin
        exp_t r;
        logic [2:0] m;
        rst_n = 1'b0;
        mode = 3'd0; ctrl = 2'b00; data = '0; terc = '0;
        for (int k = 0; k < 4; k++) cnt_m[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tmds3", 64'(tmds3), 64'd0);
        chk("rst_disp3", 64'(disp3), 64'd0);
        chk("rst_tmds4", 64'(tmds4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // First word out of reset comes from the cleared stage-1 registers
        r.mode = 3'd0; r.data = '0; r.disp = '0;
        for (int k = 0; k < 4; k++) r.sym[10*k +: 10] = 10'b1101010100;
        q.push_back(r);

        drive(3'd0, 2'b00, 32'h0, 16'h0);
        lit("rst_word0", 0, 10'b1101010100);
        drive(3'd0, 2'b10, 32'h0, 16'h0);
        lit("rst_word1", 0, 10'b1101010100);
        drive(3'd1, 2'b00, 32'h0, 16'h0);
        lit("ctrl10_ch0", 0, 10'b0101010100);
        lit("ctrl10_ch1", 1, 10'b1101010100);
        lit("ctrl10_ch2", 2, 10'b1101010100);
        drive(3'd1, 2'b00, 32'h0, 16'h0);
        lit("vid0_a", 0, 10'b0100000000);
        lit_disp("vid0_a_disp", 5'b11000);
        drive(3'd1, 2'b00, 32'h0, 16'h0);
        lit("vid0_b", 0, 10'b1111111111);
        lit("vid0_b_ch2", 2, 10'b1111111111);
        lit_disp("vid0_b_disp", 5'd2);
        drive(3'd0, 2'b00, 32'h0, 16'h0);
        lit("vid0_c", 0, 10'b0100000000);
        lit_disp("vid0_c_disp", 5'b11010);
        drive(3'd1, 2'b00, 32'h0, 16'h0);
        lit("ctrl_mid", 0, 10'b1101010100);
        lit_disp("ctrl_mid_disp", 5'd0);
        drive(3'd0, 2'b00, 32'h0, 16'h0);
        lit_disp("vid_m8_disp", 5'b11000);
        drive(3'd1, 2'b00, 32'h0, 16'h0);
        lit_disp("ctrl_clr_disp", 5'd0);
        drive(3'd2, 2'b00, 32'h0, 16'h0);
        lit("vid_restart", 0, 10'b0100000000);
        drive(3'd3, 2'b00, 32'h0, 16'h0F50);
        lit("vgb_ch0", 0, 10'b1011001100);
        lit("vgb_ch1", 1, 10'b0100110011);
        lit("vgb_ch2", 2, 10'b1011001100);
        drive(3'd4, 2'b01, 32'h0, 16'h0);
        lit("terc_ch0", 0, 10'b1010011100);
        lit("terc_ch1", 1, 10'b0100011110);
        lit("terc_ch2", 2, 10'b1011000011);
        drive(3'd0, 2'b00, 32'h0, 16'h0);
        lit("dgb_ch0", 0, 10'b1001110001);
        lit("dgb_ch1", 1, 10'b0100110011);

        // VIDEO/DATA alternation every cycle
        for (int i = 0; i < 2000; i++)
            drive((i % 2 == 0) ? 3'd1 : 3'd3, 2'($urandom), $urandom, 16'($urandom));
        // Any mode, including the 5-7 aliases of CTRL
        for (int i = 0; i < 3000; i++) begin
            m = 3'($urandom);
            if ($urandom_range(0, 1) == 0) m = 3'd1;
            drive(m, 2'($urandom), $urandom, 16'($urandom));
        end
        // Long video run
        for (int i = 0; i < 20000; i++)
            drive(3'd1, 2'($urandom), $urandom, 16'($urandom));
        drive(3'd0, 2'b00, 32'h0, 16'h0);
        drive(3'd0, 2'b00, 32'h0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
